// File: rtl/idct_izigzag_buf_pkg.sv
// rtl/idct_izigzag_buf_pkg.sv - shared widths and zigzag scan table for the inverse-zigzag buffer
//
// Purpose : constants shared by the inverse-zigzag ping-pong buffer and its ROM.
//   DW           coefficient width (two's complement), matches IDCTTop data_in
//   NCOEF        coefficients per 8x8 block
//   AW           address width, log2(NCOEF)
//   ZZ_TO_RASTER zigzag scan index -> raster (row-major) address
package idct_pkg;

  localparam int DW    = 16;
  localparam int NCOEF = 64;
  localparam int AW    = 6;

  localparam logic [AW-1:0] ZZ_TO_RASTER [0:NCOEF-1] = '{
    6'd0,  6'd1,  6'd8,  6'd16, 6'd9,  6'd2,  6'd3,  6'd10,
    6'd17, 6'd24, 6'd32, 6'd25, 6'd18, 6'd11, 6'd4,  6'd5,
    6'd12, 6'd19, 6'd26, 6'd33, 6'd40, 6'd48, 6'd41, 6'd34,
    6'd27, 6'd20, 6'd13, 6'd6,  6'd7,  6'd14, 6'd21, 6'd28,
    6'd35, 6'd42, 6'd49, 6'd56, 6'd57, 6'd50, 6'd43, 6'd36,
    6'd29, 6'd22, 6'd15, 6'd23, 6'd30, 6'd37, 6'd44, 6'd51,
    6'd58, 6'd59, 6'd52, 6'd45, 6'd38, 6'd31, 6'd39, 6'd46,
    6'd53, 6'd60, 6'd61, 6'd54, 6'd47, 6'd55, 6'd62, 6'd63
  };

endpackage

// File: rtl/idct_izigzag_buf_if.sv
// rtl/idct_izigzag_buf_if.sv - coefficient input and raster output stream bundle
//
// Purpose : groups the zigzag-order input handshake and the raster-order output
//           stream of the inverse-zigzag buffer.
//   coef_in/coef_mode/coef_valid  master -> slave, zigzag-order coefficients
//   coef_ready                    slave -> master, beat transfers on valid & ready
//   data_out/mode_out             slave -> master, raster-order data and block mode
//   out_valid/out_start           slave -> master, beat valid and beat-0 pulse
interface idct_izigzag_buf_if;
  import idct_pkg::*;

  logic [DW-1:0] coef_in;
  logic          coef_mode;
  logic          coef_valid;
  logic          coef_ready;
  logic [DW-1:0] data_out;
  logic          mode_out;
  logic          out_valid;
  logic          out_start;

  modport slave (
    input  coef_in, coef_mode, coef_valid,
    output coef_ready, data_out, mode_out, out_valid, out_start
  );

  modport master (
    output coef_in, coef_mode, coef_valid,
    input  coef_ready, data_out, mode_out, out_valid, out_start
  );

endinterface

// File: rtl/idct_izigzag_buf_zigzag_rom.sv
// rtl/idct_izigzag_buf_zigzag_rom.sv - combinational zigzag scan index to raster address lookup
//
// Purpose : maps the position of a coefficient in JPEG zigzag scan order to its
//           row-major address inside the 8x8 block.
//   i_idx   in  AW  zigzag scan index 0..63
//   o_addr  out AW  raster address 0..63
module idct_zigzag_rom
  import idct_pkg::*;
(
  input  logic [AW-1:0] i_idx,
  output logic [AW-1:0] o_addr
);

  assign o_addr = ZZ_TO_RASTER[i_idx];

endmodule

// File: rtl/idct_izigzag_buf.sv
// rtl/idct_izigzag_buf.sv - inverse-zigzag ping-pong block buffer feeding IDCTTop
//
// Purpose : accepts one 8x8 block of coefficients in zigzag order into one of two
//           banks, and streams a full bank to IDCTTop in raster order as 64
//           consecutive beats while the other bank is being filled.
//   clk    in  1   clock, all state on rising edge
//   rst_b  in  1   asynchronous active-low reset
//   bus    slave   coef_in/coef_mode/coef_valid/coef_ready input stream,
//                  data_out/mode_out/out_valid/out_start output stream
module idct_izigzag_buf
  import idct_pkg::*;
(
  input  logic              clk,
  input  logic              rst_b,
  idct_izigzag_buf_if.slave bus
);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_RUN  = 1'b1;

  localparam logic [AW-1:0] LAST_IDX = AW'(NCOEF - 1);

  logic [DW-1:0] r_bank [0:1][0:NCOEF-1];
  logic [1:0]    r_bank_mode;
  logic [1:0]    r_full;
  logic          r_wr_bank;
  logic          r_rd_bank;
  logic [AW-1:0] r_wr_cnt;
  logic [AW-1:0] r_rd_cnt;
  logic [0:0]    r_state;
  logic [DW-1:0] r_data_out;
  logic          r_mode_out;
  logic          r_out_valid;
  logic          r_out_start;

  logic          w_coef_ready;
  logic          w_accept;
  logic          w_wr_done;
  logic          w_rd_done;
  logic          w_other_full;
  logic [AW-1:0] w_wr_addr;

  idct_zigzag_rom u_rom (
    .i_idx  (r_wr_cnt),
    .o_addr (w_wr_addr)
  );

  assign w_coef_ready = !r_full[r_wr_bank];
  assign w_accept     = bus.coef_valid && w_coef_ready;
  assign w_wr_done    = w_accept && (r_wr_cnt == LAST_IDX);
  assign w_rd_done    = (r_state == S_RUN) && (r_rd_cnt == LAST_IDX);

  // The other bank counts as ready if it is already full or is being completed
  // on this very edge; without the second term a source streaming at full rate
  // would see a one-cycle bubble every other block.
  assign w_other_full = r_full[~r_rd_bank] ||
                        (w_wr_done && (r_wr_bank == ~r_rd_bank));

  // Coefficient storage carries no reset: validity lives entirely in r_full.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_bank[r_wr_bank][w_wr_addr] <= bus.coef_in;
    end
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      r_wr_cnt    <= '0;
      r_wr_bank   <= 1'b0;
      r_bank_mode <= '0;
    end else if (w_accept) begin
      r_wr_cnt <= r_wr_cnt + 1'b1;
      if (r_wr_cnt == '0) begin
        r_bank_mode[r_wr_bank] <= bus.coef_mode;
      end
      if (w_wr_done) begin
        r_wr_bank <= ~r_wr_bank;
      end
    end
  end

  // Writer only completes an empty bank and the reader only drains a full one,
  // so a set and a clear never target the same bank in one cycle.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      r_full <= '0;
    end else begin
      for (int b = 0; b < 2; b++) begin
        if (w_wr_done && (r_wr_bank == 1'(b))) begin
          r_full[b] <= 1'b1;
        end else if (w_rd_done && (r_rd_bank == 1'(b))) begin
          r_full[b] <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      r_state     <= S_IDLE;
      r_rd_bank   <= 1'b0;
      r_rd_cnt    <= '0;
      r_data_out  <= '0;
      r_mode_out  <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_start <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_out_valid <= 1'b0;
          r_out_start <= 1'b0;
          if (r_full[r_rd_bank]) begin
            r_state <= S_RUN;
          end
        end
        S_RUN: begin
          r_data_out  <= r_bank[r_rd_bank][r_rd_cnt];
          r_out_valid <= 1'b1;
          r_out_start <= (r_rd_cnt == '0);
          if (r_rd_cnt == '0) begin
            r_mode_out <= r_bank_mode[r_rd_bank];
          end
          r_rd_cnt <= r_rd_cnt + 1'b1;
          if (w_rd_done) begin
            r_rd_bank <= ~r_rd_bank;
            if (!w_other_full) begin
              r_state <= S_IDLE;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.coef_ready = w_coef_ready;
  assign bus.data_out   = r_data_out;
  assign bus.mode_out   = r_mode_out;
  assign bus.out_valid  = r_out_valid;
  assign bus.out_start  = r_out_start;

endmodule

// File: tb/tb_idct_izigzag_buf.sv
// tb/tb_idct_izigzag_buf.sv - self-checking bench for the inverse-zigzag ping-pong buffer
module tb_idct_izigzag_buf;

  logic clk = 1'b0;
  logic rst_b = 1'b0;
  always #5 clk = ~clk;

  idct_izigzag_buf_if bus_if ();

  idct_izigzag_buf dut (
    .clk   (clk),
    .rst_b (rst_b),
    .bus   (bus_if)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int last_acc = 0;

  logic [15:0] q_data [$];
  logic        q_mode [$];
  logic        q_start [$];
  int          q_cyc [$];

  // zigzag scan index held at each raster position (row-major)
  int inv [0:63] = '{
     0,  1,  5,  6, 14, 15, 27, 28,
     2,  4,  7, 13, 16, 26, 29, 42,
     3,  8, 12, 17, 25, 30, 41, 43,
     9, 11, 18, 24, 31, 40, 44, 53,
    10, 19, 23, 32, 39, 45, 52, 54,
    20, 22, 33, 38, 46, 51, 55, 60,
    21, 34, 37, 47, 50, 56, 59, 61,
    35, 36, 48, 49, 57, 58, 62, 63
  };

  typedef struct {
    int          p;
    logic [15:0] exp_pos;
    logic [15:0] exp_neg;
  } vec_t;
  vec_t vecs [0:11];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (bus_if.out_valid === 1'b1) begin
      q_data.push_back(bus_if.data_out);
      q_mode.push_back(bus_if.mode_out);
      q_start.push_back(bus_if.out_start);
      q_cyc.push_back(cyc);
    end
  end

  function automatic logic [15:0] coef_val(input int pat, input int k);
    int v;
    case (pat)
      0:       v = k;
      1:       v = -k;
      2:       v = (k * 1021 + 7) ^ 32'h8000;
      default: v = 32'h7fff - k * 3;
    endcase
    return v[15:0];
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic send_block(input logic mode, input int pat, input bit gaps, input bit flip,
                            input int nbeats, output int stall0);
    stall0 = 0;
    for (int k = 0; k < nbeats; k++) begin
      if (gaps) begin
        while ($urandom_range(1, 0) == 0) begin
          bus_if.coef_valid = 1'b0;
          @(posedge clk); #1;
        end
      end
      bus_if.coef_valid = 1'b1;
      bus_if.coef_in    = coef_val(pat, k);
      bus_if.coef_mode  = (k == 0) ? mode : (flip ? ~mode : mode);
      begin
        bit acc;
        int w;
        acc = 1'b0;
        w = 0;
        while (!acc) begin
          acc = bus_if.coef_ready;
          @(posedge clk); #1;
          if (!acc) begin
            w++;
            if (k == 0) stall0++;
            if (w > 1000) begin
              checks++;
              errors++;
              $display("FAIL send_timeout: beat %0d not accepted after %0d cycles", k, w);
              bus_if.coef_valid = 1'b0;
              return;
            end
          end
        end
      end
      last_acc = cyc;
    end
    bus_if.coef_valid = 1'b0;
  endtask

  task automatic wait_beats(input int n, input int budget);
    int t;
    t = 0;
    while (q_data.size() < n && t < budget) begin
      @(posedge clk); #2;
      t++;
    end
    chk("beat_count", q_data.size(), n);
  endtask

  task automatic check_block(input int base, input logic mode, input int pat, input string name);
    if (q_data.size() < base + 64) begin
      checks++;
      errors++;
      $display("FAIL %s_short: got %0d beats expected %0d", name, q_data.size() - base, 64);
      return;
    end
    for (int p = 0; p < 64; p++) begin
      chk($sformatf("%s_data_p%0d", name, p), q_data[base + p], coef_val(pat, inv[p]));
      chk($sformatf("%s_mode_p%0d", name, p), q_mode[base + p], mode);
      chk($sformatf("%s_start_p%0d", name, p), q_start[base + p], (p == 0));
    end
  endtask

  initial begin
    int base;
    int s0, s1, s2;

    vecs[0]  = '{0,  16'd0,  16'h0000};
    vecs[1]  = '{1,  16'd1,  16'hFFFF};
    vecs[2]  = '{2,  16'd5,  16'hFFFB};
    vecs[3]  = '{3,  16'd6,  16'hFFFA};
    vecs[4]  = '{8,  16'd2,  16'hFFFE};
    vecs[5]  = '{9,  16'd4,  16'hFFFC};
    vecs[6]  = '{16, 16'd3,  16'hFFFD};
    vecs[7]  = '{63, 16'd63, 16'hFFC1};
    vecs[8]  = '{4,  16'd14, 16'hFFF2};
    vecs[9]  = '{7,  16'd28, 16'hFFE4};
    vecs[10] = '{56, 16'd35, 16'hFFDD};
    vecs[11] = '{36, 16'd39, 16'hFFD9};

    bus_if.coef_in    = '0;
    bus_if.coef_mode  = 1'b0;
    bus_if.coef_valid = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_data_out", bus_if.data_out, 16'd0);
    chk("rst_mode_out", bus_if.mode_out, 1'b0);
    chk("rst_out_valid", bus_if.out_valid, 1'b0);
    chk("rst_out_start", bus_if.out_start, 1'b0);
    chk("rst_coef_ready", bus_if.coef_ready, 1'b1);
    rst_b = 1'b1;
    @(posedge clk); #1;

    // single block, values = zigzag index, mode 1
    base = q_data.size();
    send_block(1'b1, 0, 1'b0, 1'b0, 64, s0);
    wait_beats(base + 64, 400);
    if (q_data.size() >= base + 64) begin
      chk("latency_beat0", q_cyc[base], last_acc + 2);
      for (int i = 0; i < 12; i++) begin
        chk($sformatf("vec_pos_p%0d", vecs[i].p), q_data[base + vecs[i].p], vecs[i].exp_pos);
      end
    end
    check_block(base, 1'b1, 0, "blk1");
    repeat (5) @(posedge clk); #1;
    chk("idle_out_valid", bus_if.out_valid, 1'b0);

    // three blocks back-to-back, negative values, modes 0,1,0
    base = q_data.size();
    send_block(1'b0, 1, 1'b0, 1'b0, 64, s0);
    send_block(1'b1, 1, 1'b0, 1'b0, 64, s1);
    send_block(1'b0, 1, 1'b0, 1'b0, 64, s2);
    wait_beats(base + 192, 800);
    chk("b2b_stall_blk1", s0, 0);
    chk("b2b_stall_blk2", s1, 0);
    chk("b2b_stall_blk3_nonzero", (s2 > 0), 1'b1);
    if (q_data.size() >= base + 192) begin
      chk("b2b_contiguous", q_cyc[base + 191] - q_cyc[base], 191);
      for (int i = 0; i < 12; i++) begin
        chk($sformatf("vec_neg_p%0d", vecs[i].p), q_data[base + vecs[i].p], vecs[i].exp_neg);
      end
    end
    check_block(base, 1'b0, 1, "b2b0");
    check_block(base + 64, 1'b1, 1, "b2b1");
    check_block(base + 128, 1'b0, 1, "b2b2");
    repeat (10) @(posedge clk); #1;
    chk("b2b_no_extra", q_data.size(), base + 192);

    // random valid gaps with coef_mode flipped after beat 0
    base = q_data.size();
    send_block(1'b0, 2, 1'b1, 1'b1, 64, s0);
    send_block(1'b1, 2, 1'b1, 1'b1, 64, s1);
    wait_beats(base + 128, 1200);
    check_block(base, 1'b0, 2, "gap0");
    check_block(base + 64, 1'b1, 2, "gap1");

    // reset while the writer is at wr_cnt = 30
    repeat (5) @(posedge clk); #1;
    base = q_data.size();
    send_block(1'b1, 2, 1'b0, 1'b0, 30, s0);
    #1 rst_b = 1'b0;
    #1;
    chk("wrst_data_out", bus_if.data_out, 16'd0);
    chk("wrst_mode_out", bus_if.mode_out, 1'b0);
    chk("wrst_out_valid", bus_if.out_valid, 1'b0);
    chk("wrst_coef_ready", bus_if.coef_ready, 1'b1);
    @(posedge clk); #1 rst_b = 1'b1;
    repeat (100) @(posedge clk); #1;
    chk("wrst_no_beats", q_data.size(), base);
    send_block(1'b1, 3, 1'b0, 1'b0, 64, s0);
    wait_beats(base + 64, 400);
    check_block(base, 1'b1, 3, "wrst_blk");

    // reset while the reader is streaming beat 20
    repeat (5) @(posedge clk); #1;
    base = q_data.size();
    send_block(1'b1, 0, 1'b0, 1'b0, 64, s0);
    begin
      int t;
      t = 0;
      while (q_data.size() < base + 21 && t < 400) begin
        @(posedge clk); #2;
        t++;
      end
    end
    rst_b = 1'b0;
    #1;
    chk("rrst_data_out", bus_if.data_out, 16'd0);
    chk("rrst_mode_out", bus_if.mode_out, 1'b0);
    chk("rrst_out_valid", bus_if.out_valid, 1'b0);
    chk("rrst_out_start", bus_if.out_start, 1'b0);
    @(posedge clk); #1 rst_b = 1'b1;
    repeat (100) @(posedge clk); #1;
    chk("rrst_beats_stopped", q_data.size(), base + 21);
    chk("rrst_coef_ready", bus_if.coef_ready, 1'b1);
    base = q_data.size();
    send_block(1'b0, 1, 1'b0, 1'b0, 64, s0);
    wait_beats(base + 64, 400);
    check_block(base, 1'b0, 1, "rrst_blk");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
